// File: rtl/fb_pkg.sv
// Shared constants, FSM state type and lane helper for the framebuffer writer.
// A vector word holds two RGB pixels, one byte per 32-bit lane.
package fb_pkg;

    localparam int LANE_W         = 32;
    localparam int LANES_PER_WORD = 6;
    localparam int PIX_PER_WORD   = 2;
    localparam int LANES_PER_PIX  = LANES_PER_WORD / PIX_PER_WORD;

    typedef enum logic [2:0] {
        IDLE,
        FILL_A,
        FILL_B,
        WRITE,
        DONE
    } fb_wr_state_t;

    function automatic logic [LANE_W-1:0] pack_lane(input logic [7:0] i_byte);
        return {{(LANE_W-8){1'b0}}, i_byte};
    endfunction

endpackage

// File: rtl/pixel_packer.sv
// Holding register for one vector word: pixel A in lanes 0-2, pixel B in lanes 3-5,
// each channel zero-extended into its own lane.
module pixel_packer
    import fb_pkg::*;
#(
    parameter int S = 32,
    parameter int V = 192
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_clear,
    input  logic         i_load_a,
    input  logic         i_load_b,
    input  logic         i_clear_b,
    input  logic [7:0]   i_r,
    input  logic [7:0]   i_g,
    input  logic [7:0]   i_b,
    output logic [V-1:0] o_word
);

    logic [7:0]                  w_chan [LANES_PER_PIX];
    logic [LANES_PER_WORD*S-1:0] w_word;

    assign w_chan[0] = i_r;
    assign w_chan[1] = i_g;
    assign w_chan[2] = i_b;

    genvar gi;
    generate
        for (gi = 0; gi < LANES_PER_WORD; gi++) begin : g_lane
            localparam int CH   = gi % LANES_PER_PIX;
            localparam bit IS_B = (gi >= LANES_PER_PIX);

            logic [S-1:0] r_lane;
            logic         w_load;
            logic         w_zero;

            assign w_load = IS_B ? i_load_b : i_load_a;
            // Upper lanes are also zeroed when the odd final pixel closes a word.
            assign w_zero = i_clear | (IS_B & i_clear_b);

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_lane <= '0;
                end else if (w_load) begin
                    r_lane <= S'(pack_lane(w_chan[CH]));
                end else if (w_zero) begin
                    r_lane <= '0;
                end
            end

            assign w_word[gi*S +: S] = r_lane;
        end
    endgenerate

    assign o_word = V'(w_word);

endmodule

// File: rtl/framebuffer_writer.sv
// Packs an RGB pixel stream two-per-word and writes each word to BASE + 3*pixel_index,
// holding the request until the memory controller accepts it.
module framebuffer_writer
    import fb_pkg::*;
#(
    parameter int S      = 32,
    parameter int V      = 192,
    parameter int WIDTH  = 100,
    parameter int HEIGHT = 100,
    parameter int BASE   = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         pix_valid,
    output logic         pix_ready,
    input  logic [7:0]   pix_r,
    input  logic [7:0]   pix_g,
    input  logic [7:0]   pix_b,
    output logic         mem_we,
    output logic [S-1:0] mem_addr,
    output logic [V-1:0] mem_wd,
    input  logic         mem_ready,
    output logic         busy,
    output logic         done
);

    localparam int           TOTAL  = WIDTH * HEIGHT;
    localparam logic [S-1:0] TOTAL_S = S'(TOTAL);
    localparam logic [S-1:0] LAST_S  = S'(TOTAL - 1);
    localparam logic [S-1:0] BASE_S  = S'(BASE);

    fb_wr_state_t r_state;
    fb_wr_state_t w_state_next;

    logic [S-1:0] r_pix_idx;
    logic [S-1:0] r_mem_addr;

    logic w_pix_ready;
    logic w_mem_we;
    logic w_busy;
    logic w_done;
    logic w_clear;
    logic w_load_a;
    logic w_load_b;
    logic w_clear_b;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Outputs decode r_state only; pix_valid/mem_ready steer transitions, never pix_ready.
    always_comb begin
        w_state_next = r_state;
        w_pix_ready  = 1'b0;
        w_mem_we     = 1'b0;
        w_busy       = 1'b0;
        w_done       = 1'b0;
        w_clear      = 1'b0;
        w_load_a     = 1'b0;
        w_load_b     = 1'b0;
        w_clear_b    = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_clear      = 1'b1;
                    w_state_next = FILL_A;
                end
            end
            FILL_A: begin
                w_pix_ready = 1'b1;
                w_busy      = 1'b1;
                if (pix_valid) begin
                    w_load_a = 1'b1;
                    if (r_pix_idx == LAST_S) begin
                        w_clear_b    = 1'b1;
                        w_state_next = WRITE;
                    end else begin
                        w_state_next = FILL_B;
                    end
                end
            end
            FILL_B: begin
                w_pix_ready = 1'b1;
                w_busy      = 1'b1;
                if (pix_valid) begin
                    w_load_b     = 1'b1;
                    w_state_next = WRITE;
                end
            end
            WRITE: begin
                w_mem_we = 1'b1;
                w_busy   = 1'b1;
                if (mem_ready) begin
                    w_state_next = (r_pix_idx < TOTAL_S) ? FILL_A : DONE;
                end
            end
            DONE: begin
                w_done       = 1'b1;
                w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pix_idx  <= '0;
            r_mem_addr <= '0;
        end else if (w_clear) begin
            r_pix_idx <= '0;
        end else if (w_load_a) begin
            r_pix_idx  <= r_pix_idx + S'(1);
            r_mem_addr <= BASE_S + r_pix_idx * S'(3);
        end else if (w_load_b) begin
            r_pix_idx <= r_pix_idx + S'(1);
        end
    end

    pixel_packer #(
        .S (S),
        .V (V)
    ) u_packer (
        .clk       (clk),
        .rst       (rst),
        .i_clear   (w_clear),
        .i_load_a  (w_load_a),
        .i_load_b  (w_load_b),
        .i_clear_b (w_clear_b),
        .i_r       (pix_r),
        .i_g       (pix_g),
        .i_b       (pix_b),
        .o_word    (mem_wd)
    );

    assign pix_ready = w_pix_ready;
    assign mem_we    = w_mem_we;
    assign mem_addr  = r_mem_addr;
    assign busy      = w_busy;
    assign done      = w_done;

endmodule

// File: tb/tb_framebuffer_writer.sv
// Scoreboarded bench for framebuffer_writer: four instances with different frame geometries,
// driven one at a time through directed steps.
module tb_framebuffer_writer;

    typedef struct {
        logic [31:0]  addr;
        logic [191:0] wd;
    } wr_t;

    logic         clk;
    logic         rst;
    logic         start     [4];
    logic         pix_valid [4];
    logic         mem_ready [4];
    logic [7:0]   pix_r     [4];
    logic [7:0]   pix_g     [4];
    logic [7:0]   pix_b     [4];
    logic         pix_ready [4];
    logic         mem_we    [4];
    logic         busy      [4];
    logic         done      [4];
    logic [31:0]  mem_addr  [4];
    logic [191:0] mem_wd    [4];

    int n_tests = 0;
    int n_fail  = 0;

    wr_t          exp_q[$];
    int           cur;
    int           src_idx;
    int           src_total;
    int           exp_words;
    int           accepts;
    int           done_cnt;
    int           valid_pct;
    int           mem_mode;
    int           cyc;
    int           last_hs_cyc;
    logic [31:0]  base_cur;
    logic         prev_we;
    logic [191:0] bw;
    logic [31:0]  ba;

    framebuffer_writer #(.WIDTH(2), .HEIGHT(1), .BASE(0)) u_fb0 (
        .clk(clk), .rst(rst), .start(start[0]), .pix_valid(pix_valid[0]), .pix_ready(pix_ready[0]),
        .pix_r(pix_r[0]), .pix_g(pix_g[0]), .pix_b(pix_b[0]), .mem_we(mem_we[0]),
        .mem_addr(mem_addr[0]), .mem_wd(mem_wd[0]), .mem_ready(mem_ready[0]),
        .busy(busy[0]), .done(done[0])
    );

    framebuffer_writer #(.WIDTH(3), .HEIGHT(1), .BASE(256)) u_fb1 (
        .clk(clk), .rst(rst), .start(start[1]), .pix_valid(pix_valid[1]), .pix_ready(pix_ready[1]),
        .pix_r(pix_r[1]), .pix_g(pix_g[1]), .pix_b(pix_b[1]), .mem_we(mem_we[1]),
        .mem_addr(mem_addr[1]), .mem_wd(mem_wd[1]), .mem_ready(mem_ready[1]),
        .busy(busy[1]), .done(done[1])
    );

    framebuffer_writer u_fb2 (
        .clk(clk), .rst(rst), .start(start[2]), .pix_valid(pix_valid[2]), .pix_ready(pix_ready[2]),
        .pix_r(pix_r[2]), .pix_g(pix_g[2]), .pix_b(pix_b[2]), .mem_we(mem_we[2]),
        .mem_addr(mem_addr[2]), .mem_wd(mem_wd[2]), .mem_ready(mem_ready[2]),
        .busy(busy[2]), .done(done[2])
    );

    framebuffer_writer #(.WIDTH(1), .HEIGHT(1), .BASE(0)) u_fb3 (
        .clk(clk), .rst(rst), .start(start[3]), .pix_valid(pix_valid[3]), .pix_ready(pix_ready[3]),
        .pix_r(pix_r[3]), .pix_g(pix_g[3]), .pix_b(pix_b[3]), .mem_we(mem_we[3]),
        .mem_addr(mem_addr[3]), .mem_wd(mem_wd[3]), .mem_ready(mem_ready[3]),
        .busy(busy[3]), .done(done[3])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_int(input string tag, input int obs, input int exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_vec(input string tag, input logic [191:0] obs, input logic [191:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Pixels 0 and 1 are (11,22,33) and (44,55,66); later pixels vary with index.
    function automatic logic [23:0] pix_of(input int idx);
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        r = 8'(17 + idx * 51);
        g = 8'(r + 8'h11) ^ 8'(idx >> 3);
        b = 8'(r + 8'h22) ^ 8'(idx >> 5);
        return {r, g, b};
    endfunction

    task automatic drive();
        logic [23:0] p;
        p = pix_of(src_idx);
        pix_valid[cur] = (src_idx < src_total) && (int'($urandom_range(99)) < valid_pct);
        {pix_r[cur], pix_g[cur], pix_b[cur]} = p;
        case (mem_mode)
            0:       mem_ready[cur] = 1'b1;
            1:       mem_ready[cur] = 1'b0;
            default: mem_ready[cur] = 1'($urandom_range(1));
        endcase
    endtask

    // Reference packing: push the expected word once its last pixel is handed over.
    task automatic model_accept();
        logic [23:0] p;
        p = pix_of(src_idx);
        if ((src_idx % 2) == 0) begin
            bw          = '0;
            bw[7:0]     = p[23:16];
            bw[39:32]   = p[15:8];
            bw[71:64]   = p[7:0];
            ba          = base_cur + 32'(3 * src_idx);
            if (src_idx == src_total - 1) exp_q.push_back('{addr: ba, wd: bw});
        end else begin
            bw[103:96]  = p[23:16];
            bw[135:128] = p[15:8];
            bw[167:160] = p[7:0];
            exp_q.push_back('{addr: ba, wd: bw});
        end
        src_idx++;
    endtask

    task automatic cycle();
        wr_t e;
        @(negedge clk);
        cyc++;
        if (pix_valid[cur] && pix_ready[cur]) begin
            model_accept();
            last_hs_cyc = cyc;
        end
        if (mem_we[cur] && !prev_we) check_int("write_latency", cyc - last_hs_cyc, 1);
        prev_we = mem_we[cur];
        if (mem_we[cur] && mem_ready[cur]) begin
            check_int("write_expected", int'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                $display("[TB] write inst=%0d addr=%0h data=%0h", cur, mem_addr[cur], mem_wd[cur]);
                check_vec("write_addr", 192'(mem_addr[cur]), 192'(e.addr));
                check_vec("write_data", mem_wd[cur], e.wd);
            end
            accepts++;
        end
        if (done[cur]) begin
            done_cnt++;
            check_int("done_after_last_write", accepts, exp_words);
            check_vec("done_busy_low", 192'(busy[cur]), 192'(0));
        end
        @(posedge clk);
        #1;
        drive();
    endtask

    task automatic start_frame(input int inst, input int total, input logic [31:0] base, input bit hold);
        for (int i = 0; i < 4; i++) begin
            start[i]     = 1'b0;
            pix_valid[i] = 1'b0;
            mem_ready[i] = 1'b0;
        end
        cur       = inst;
        src_total = total;
        base_cur  = base;
        src_idx   = 0;
        exp_q.delete();
        exp_words = (total + 1) / 2;
        accepts   = 0;
        done_cnt  = 0;
        prev_we   = 1'b0;
        start[cur] = 1'b1;
        drive();
        cycle();
        if (!hold) start[cur] = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (done_cnt == 0 && n < budget) begin
            cycle();
            n++;
        end
        check_int("frame_done_in_budget", int'(done_cnt > 0), 1);
    endtask

    task automatic end_frame_checks();
        cycle();
        check_vec("idle_busy", 192'(busy[cur]), 192'(0));
        check_vec("idle_done", 192'(done[cur]), 192'(0));
        check_vec("idle_mem_we", 192'(mem_we[cur]), 192'(0));
        check_int("write_count", accepts, exp_words);
        check_int("done_pulses", done_cnt, 1);
        check_int("pending_words", exp_q.size(), 0);
        check_int("pixels_accepted", src_idx, src_total);
    endtask

    initial begin
        int n;
        for (int i = 0; i < 4; i++) begin
            start[i] = 1'b0; pix_valid[i] = 1'b0; mem_ready[i] = 1'b0;
            pix_r[i] = 8'h0; pix_g[i] = 8'h0; pix_b[i] = 8'h0;
        end
        cur = 0; src_idx = 0; src_total = 0; exp_words = 0; accepts = 0; done_cnt = 0;
        valid_pct = 100; mem_mode = 0; cyc = 0; last_hs_cyc = 0; base_cur = '0; prev_we = 1'b0;
        bw = '0; ba = '0;

        // Reset values
        rst = 1'b1;
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
        check_vec("rst_pix_ready", 192'(pix_ready[0]), 192'(0));
        check_vec("rst_mem_we", 192'(mem_we[0]), 192'(0));
        check_vec("rst_mem_addr", 192'(mem_addr[0]), 192'(0));
        check_vec("rst_mem_wd", mem_wd[0], 192'(0));
        check_vec("rst_busy", 192'(busy[0]), 192'(0));
        check_vec("rst_done", 192'(done[0]), 192'(0));
        @(posedge clk);
        #1 rst = 1'b1;

        // 2x1 frame, single word
        valid_pct = 100; mem_mode = 0;
        start_frame(0, 2, 32'h0, 1'b0);
        wait_done(100);
        end_frame_checks();

        // 3x1 frame at 0x100, odd final pixel
        start_frame(1, 3, 32'h100, 1'b0);
        wait_done(100);
        end_frame_checks();

        // pix_valid stall, then mem_ready held low in WRITE
        valid_pct = 0; mem_mode = 1;
        start_frame(1, 3, 32'h100, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cycle();
            check_vec("stall_pix_ready", 192'(pix_ready[1]), 192'(1));
            check_vec("stall_mem_we", 192'(mem_we[1]), 192'(0));
            check_vec("stall_busy", 192'(busy[1]), 192'(1));
            check_int("stall_no_accept", src_idx, 0);
        end
        valid_pct = 100;
        n = 0;
        while (!mem_we[1] && n < 20) begin cycle(); n++; end
        check_vec("hold_reached_write", 192'(mem_we[1]), 192'(1));
        for (int i = 0; i < 5; i++) begin
            cycle();
            check_vec("hold_mem_we", 192'(mem_we[1]), 192'(1));
            check_vec("hold_pix_ready", 192'(pix_ready[1]), 192'(0));
            if (exp_q.size() > 0) begin
                check_vec("hold_mem_addr", 192'(mem_addr[1]), 192'(exp_q[0].addr));
                check_vec("hold_mem_wd", mem_wd[1], exp_q[0].wd);
            end
        end
        check_int("hold_no_accept", accepts, 0);
        mem_mode = 0;
        wait_done(100);
        end_frame_checks();

        // Full 100x100 frame with random valid and random mem_ready
        valid_pct = 60; mem_mode = 2;
        start_frame(2, 10000, 32'h0, 1'b0);
        wait_done(60000);
        end_frame_checks();

        // Reset while a word is pending, then refill from BASE
        valid_pct = 100; mem_mode = 0;
        start_frame(1, 3, 32'h100, 1'b0);
        n = 0;
        while (accepts < 1 && n < 50) begin cycle(); n++; end
        mem_mode = 1;
        n = 0;
        while (!mem_we[1] && n < 50) begin cycle(); n++; end
        check_int("abort_first_word_done", accepts, 1);
        check_vec("abort_in_write", 192'(mem_we[1]), 192'(1));
        #3 rst = 1'b0;
        #1;
        check_vec("abort_mem_we", 192'(mem_we[1]), 192'(0));
        check_vec("abort_busy", 192'(busy[1]), 192'(0));
        check_vec("abort_mem_wd", mem_wd[1], 192'(0));
        @(posedge clk);
        #1 rst = 1'b1;
        mem_mode = 0;
        start_frame(1, 3, 32'h100, 1'b0);
        wait_done(100);
        end_frame_checks();

        // 1x1 frame with start held through the frame and DONE
        start_frame(3, 1, 32'h0, 1'b1);
        wait_done(100);
        start[3] = 1'b0;
        end_frame_checks();
        cycle();
        check_vec("no_restart_busy", 192'(busy[3]), 192'(0));
        check_vec("no_restart_pix_ready", 192'(pix_ready[3]), 192'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
